// File: rtl/feed_parser.sv
// Framed market-data byte parser: SOF, type, big-endian price/quantity, XOR checksum.
// Validates type and checksum, enforces an inter-byte timeout, keeps saturating counters.
module feed_parser #(
  parameter int unsigned PRICE_BYTES = 4,
  parameter int unsigned QTY_BYTES   = 4,
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     packet_detected,
  output logic [7:0]               msg_type,
  output logic [8*PRICE_BYTES-1:0] price,
  output logic [8*QTY_BYTES-1:0]   quantity,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [15:0]              good_count,
  output logic [15:0]              err_count
);

  localparam int unsigned PRICE_W = 8 * PRICE_BYTES;
  localparam int unsigned QTY_W   = 8 * QTY_BYTES;
  localparam int unsigned GAP_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] ERR_TYPE    = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TYPE  = 3'd1,
    PRICE = 3'd2,
    QTY   = 3'd3,
    CSUM  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [7:0]           csum_q, csum_d;
  logic [7:0]           type_sh_q, type_sh_d;
  logic [PRICE_W-1:0]   price_sh_q, price_sh_d;
  logic [QTY_W-1:0]     qty_sh_q, qty_sh_d;
  logic                 pkt_q, pkt_d;
  logic                 error_q, error_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [7:0]           msg_type_q, msg_type_d;
  logic [PRICE_W-1:0]   price_q, price_d;
  logic [QTY_W-1:0]     qty_q, qty_d;
  logic [15:0]          good_cnt_q, good_cnt_d;
  logic [15:0]          err_cnt_q, err_cnt_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      csum_q     <= '0;
      type_sh_q  <= '0;
      price_sh_q <= '0;
      qty_sh_q   <= '0;
      pkt_q      <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
      msg_type_q <= '0;
      price_q    <= '0;
      qty_q      <= '0;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      csum_q     <= csum_d;
      type_sh_q  <= type_sh_d;
      price_sh_q <= price_sh_d;
      qty_sh_q   <= qty_sh_d;
      pkt_q      <= pkt_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      msg_type_q <= msg_type_d;
      price_q    <= price_d;
      qty_q      <= qty_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next-state, field assembly, timeout and result logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    csum_d     = csum_q;
    type_sh_d  = type_sh_q;
    price_sh_d = price_sh_q;
    qty_sh_d   = qty_sh_q;
    pkt_d      = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    msg_type_d = msg_type_q;
    price_d    = price_q;
    qty_d      = qty_q;

    if (rx_valid) begin
      gap_d = '0;
      unique case (state_q)
        IDLE: begin
          if (rx_data == SOF_BYTE) state_d = TYPE;
        end
        TYPE: begin
          if (rx_data == 8'h41 || rx_data == 8'h58 || rx_data == 8'h45) begin
            state_d   = PRICE;
            type_sh_d = rx_data;
            csum_d    = rx_data;
            cnt_d     = '0;
          end else begin
            state_d    = IDLE;
            error_d    = 1'b1;
            err_code_d = ERR_TYPE;
          end
        end
        PRICE: begin
          price_sh_d = (price_sh_q << 8) | PRICE_W'(rx_data);
          csum_d     = csum_q ^ rx_data;
          if (cnt_q == CNT_W'(PRICE_BYTES - 1)) begin
            state_d = QTY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        QTY: begin
          qty_sh_d = (qty_sh_q << 8) | QTY_W'(rx_data);
          csum_d   = csum_q ^ rx_data;
          if (cnt_q == CNT_W'(QTY_BYTES - 1)) begin
            state_d = CSUM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CSUM: begin
          state_d = IDLE;
          if (rx_data == csum_q) begin
            pkt_d      = 1'b1;
            msg_type_d = type_sh_q;
            price_d    = price_sh_q;
            qty_d      = qty_sh_q;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A byte on the cycle the gap would expire wins, so only idle cycles count
      if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
        state_d    = IDLE;
        gap_d      = '0;
        cnt_d      = '0;
        error_d    = 1'b1;
        err_code_d = ERR_TIMEOUT;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end

    good_cnt_d = (pkt_d && good_cnt_q != 16'hFFFF) ? good_cnt_q + 16'd1 : good_cnt_q;
    err_cnt_d  = (error_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  assign packet_detected = pkt_q;
  assign error           = error_q;
  assign err_code        = err_code_q;
  assign msg_type        = msg_type_q;
  assign price           = price_q;
  assign quantity        = qty_q;
  assign good_count      = good_cnt_q;
  assign err_count       = err_cnt_q;

endmodule

// File: tb/tb_feed_parser.sv
// Directed scoreboard bench for feed_parser: default build plus a 2/1-byte field build.
module tb_feed_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        packet_detected, error;
  logic [7:0]  msg_type;
  logic [31:0] price, quantity;
  logic [1:0]  err_code;
  logic [15:0] good_count, err_count;

  logic        rst2 = 1'b1;
  logic [7:0]  rx_data2 = 8'h00;
  logic        rx_valid2 = 1'b0;
  logic        packet_detected2, error2;
  logic [7:0]  msg_type2;
  logic [15:0] price2;
  logic [7:0]  quantity2;
  logic [1:0]  err_code2;
  logic [15:0] good_count2, err_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        good;
    logic [1:0]  code;
    logic [7:0]  typ;
    logic [31:0] price;
    logic [31:0] qty;
    logic [15:0] gc;
    logic [15:0] ec;
  } exp_t;

  exp_t sb[$];

  logic [7:0]  m_typ   = 8'h00;
  logic [31:0] m_price = 32'h0;
  logic [31:0] m_qty   = 32'h0;
  logic [1:0]  m_code  = 2'd0;
  logic [15:0] m_gc    = 16'd0;
  logic [15:0] m_ec    = 16'd0;

  always #5 clk = ~clk;

  feed_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .packet_detected(packet_detected), .msg_type(msg_type), .price(price),
    .quantity(quantity), .error(error), .err_code(err_code),
    .good_count(good_count), .err_count(err_count)
  );

  feed_parser #(.PRICE_BYTES(2), .QTY_BYTES(1)) dut2 (
    .clk(clk), .rst(rst2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .packet_detected(packet_detected2), .msg_type(msg_type2), .price(price2),
    .quantity(quantity2), .error(error2), .err_code(err_code2),
    .good_count(good_count2), .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    rx_data2  = b;
    rx_valid2 = 1'b1;
    @(negedge clk);
    rx_valid2 = 1'b0;
  endtask

  // Push the expected outcome, then drive SOF, type, fields (optional gap after price) and checksum
  task automatic send_frame(input logic [7:0] typ, input logic [31:0] p, input logic [31:0] q,
                            input bit corrupt, input int gap);
    logic [7:0] cs;
    exp_t e;
    bit type_ok;
    type_ok = (typ == 8'h41) || (typ == 8'h58) || (typ == 8'h45);
    cs = typ;
    for (int i = 0; i < 4; i++) cs ^= p[8*i +: 8] ^ q[8*i +: 8];
    if (corrupt) cs ^= 8'h01;
    if (!type_ok) m_code = 2'd1;
    else if (gap >= 16) m_code = 2'd3;
    else if (corrupt) m_code = 2'd2;
    e.good = type_ok && gap < 16 && !corrupt;
    if (e.good) begin
      m_typ = typ; m_price = p; m_qty = q;
      if (m_gc != 16'hFFFF) m_gc++;
    end else if (m_ec != 16'hFFFF) m_ec++;
    e.code = m_code; e.typ = m_typ; e.price = m_price; e.qty = m_qty;
    e.gc = m_gc; e.ec = m_ec;
    sb.push_back(e);
    send_byte(8'hA5);
    send_byte(typ);
    if (type_ok) begin
      for (int i = 3; i >= 0; i--) send_byte(p[8*i +: 8]);
      repeat (gap) @(negedge clk);
      for (int i = 3; i >= 0; i--) send_byte(q[8*i +: 8]);
      send_byte(cs);
    end
  endtask

  // Scoreboard: each pulse pops one expected outcome
  always @(negedge clk) begin
    if (!rst) begin
      chk("pulse_exclusive", 64'(packet_detected & error), 64'd0);
      if (packet_detected || error) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 64'(packet_detected), 64'(error));
          chk("unexpected_pulse_any", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("packet_detected", 64'(packet_detected), 64'(e.good));
          chk("err_code", 64'(err_code), 64'(e.code));
          chk("msg_type", 64'(msg_type), 64'(e.typ));
          chk("price", 64'(price), 64'(e.price));
          chk("quantity", 64'(quantity), 64'(e.qty));
          chk("good_count", 64'(good_count), 64'(e.gc));
          chk("err_count", 64'(err_count), 64'(e.ec));
        end
      end
    end
  end

  initial begin
    // Reset state of the default build
    @(negedge clk);
    chk("rst_pkt", 64'(packet_detected), 64'd0);
    chk("rst_err", 64'(error), 64'd0);
    chk("rst_price", 64'(price), 64'd0);
    chk("rst_qty", 64'(quantity), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_counts", 64'({good_count, err_count}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    send_frame(8'h41, 32'd1000, 32'd100, 1'b1, 0);   // bad checksum CF
    send_frame(8'h41, 32'd1000, 32'd100, 1'b0, 0);   // good, checksum CE
    send_frame(8'h5A, 32'd0, 32'd0, 1'b0, 0);        // bad type
    send_frame(8'h45, 32'h0000_0BB8, 32'd7, 1'b0, 0);
    @(negedge clk);
    send_frame(8'h41, 32'd1000, 32'd100, 1'b0, 16);  // timeout
    send_frame(8'h41, 32'd2000, 32'd300, 1'b0, 15);  // gap just under limit
    send_byte(8'h00);                                 // leading garbage
    send_frame(8'h7F, 32'd0, 32'd0, 1'b0, 0);
    send_frame(8'h58, 32'd1, 32'd2, 1'b0, 0);
    send_frame(8'h58, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("final_good_count", 64'(good_count), 64'd5);
    chk("final_err_count", 64'(err_count), 64'd4);
    chk("final_err_code", 64'(err_code), 64'd1);

    // Narrow-field build
    rst2 = 1'b0;
    @(negedge clk);
    send2(8'hA5); send2(8'h45); send2(8'h12); send2(8'h34); send2(8'h05); send2(8'h66);
    chk("p2_pkt", 64'(packet_detected2), 64'd1);
    chk("p2_type", 64'(msg_type2), 64'h45);
    chk("p2_price", 64'(price2), 64'h1234);
    chk("p2_qty", 64'(quantity2), 64'h05);
    chk("p2_good_count", 64'(good_count2), 64'd1);
    send2(8'hA5); send2(8'h45); send2(8'h12);
    rst2 = 1'b1;
    #1;
    chk("p2_rst_price", 64'(price2), 64'd0);
    chk("p2_rst_qty", 64'(quantity2), 64'd0);
    chk("p2_rst_type", 64'(msg_type2), 64'd0);
    chk("p2_rst_count", 64'(good_count2), 64'd0);
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("p2_no_pulse", 64'({packet_detected2, error2}), 64'd0);
    end
    chk("p2_err_count", 64'(err_count2), 64'd0);
    send2(8'hA5); send2(8'h41); send2(8'hA5); send2(8'h00); send2(8'h7F); send2(8'h9B);
    chk("p2_sof_as_data_pkt", 64'(packet_detected2), 64'd1);
    chk("p2_sof_as_data_price", 64'(price2), 64'hA500);
    chk("p2_sof_as_data_qty", 64'(quantity2), 64'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
